fetch: RTL and testbench
========================

Name: fetch

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Holds the architectural PC and reads the instruction BRAM, which has a 1-cycle registered read.
- Presents each instruction to decode with a valid strobe.
- Consumes decode's npc, hazard, stop and wait_time to sequence the next fetch: one-cycle branch replay, multi-cycle execute stall, and halt.

Parameters:
RESET_PC, 32'h0, PC loaded on reset
ADDR_W, 16, instruction-memory word-address width (imem depth 2^ADDR_W words)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  begin execution from IDLE
imem_addr  out  ADDR_W  word address to instruction BRAM, always pc[ADDR_W+1:2]
imem_rdata  in  32  BRAM read data, valid one cycle after address
pc  out  32  PC of presented instruction (registered)
inst  out  32  instruction to decode; imem_rdata when inst_valid=1, else 0
inst_valid  out  1  decode must evaluate inst this cycle
npc  in  32  next PC computed by decode (combinational from inst)
hazard  in  1  decode requests one replay cycle
stop  in  1  decode saw halt instruction
wait_time  in  5  execute latency of presented instruction, in cycles
busy  out  1  state is FETCH, DECODE or WAIT
halted  out  1  state is HALT
retired  out  32  count of accepted instructions

Behaviour:
- Single clock domain. Reset is synchronous, active-high and fully overrides all inputs.
- Reset values:
  - state=IDLE, pc=RESET_PC, inst_valid=0, inst=0, busy=0, halted=0, retired=0, wait counter=0, replay flag=0.
- States: IDLE, FETCH, DECODE, WAIT, HALT.
- IDLE:
  - start=1 -> FETCH.
  - start is ignored in every other state.
- FETCH (1 cycle):
  - imem_addr already reflects pc; BRAM latches it this cycle.
  - Always -> DECODE.
- DECODE:
  - inst_valid=1; inst=imem_rdata.
  - imem_addr stays constant, so rdata stays stable across a replay.
- First DECODE cycle with hazard=1 and replay flag=0:
  - Set replay flag.
  - Stay in DECODE; npc is ignored; pc unchanged.
- Otherwise the instruction is accepted. Priority:
  - stop=1 -> HALT. pc and retired unchanged.
  - Else: pc <= {npc[31:2],2'b00}; retired <= retired+1 (wraps mod 2^32); replay flag cleared.
    - Effective wait w = max(wait_time,1).
    - w=1 -> FETCH.
    - Else -> WAIT with counter=w-1.
- hazard is honoured at most once per instruction; in the replay cycle it is ignored.
- WAIT:
  - inst_valid=0. Counter decrements each cycle.
  - On the cycle counter==1 -> FETCH, so WAIT lasts exactly w-1 cycles.
  - wait_time=31 gives 30 WAIT cycles.
- HALT: inst_valid=0, halted=1; terminal until rst.
- Throughput: 2 + (w-1) + replay cycles per instruction; no overlap between instructions.
- Reset mid-operation (any state): next cycle is IDLE with reset values; any in-flight instruction is dropped and not counted.
- npc beyond 2^(ADDR_W+2): pc keeps the full 32 bits; imem_addr truncates (wraps).

Decomposition:
- Shared constant package gains:
  - fetch_state_t enum {IDLE, FETCH, DECODE, WAIT, HALT}.
  - WAIT_W=5.
  - Default RESET_PC constant.
- One natural sub-module: fetch_wait_counter.
  - Ports: load, load value w-1, tick, done (counter==1).
  - Isolates the stall countdown for reuse by a future memory stage.
- Everything else stays in fetch.

Test Plan:
1. rst, then start pulse; imem[0]=addi, wait_time=1, npc=4 -> FETCH at cycle 1 (imem_addr=0); inst_valid=1, pc=0 at cycle 2; pc=4, retired=1 at cycle 3 (FETCH, imem_addr=1).
2. Instruction with wait_time=5 (mult) accepted at cycle t -> inst_valid low for cycles t+1..t+4 (4 WAIT cycles); FETCH at t+5; inst_valid again at t+6.
3. DECODE pc=0x20 with hazard=1 held both cycles, npc=0x40 -> inst_valid high 2 consecutive cycles with pc=0x20 and identical inst; then pc=0x40; retired increments by exactly 1.
4. stop=1 in DECODE -> halted=1 next cycle, busy=0, inst_valid=0 thereafter; start pulses ignored; pc and retired frozen.
5. rst asserted during WAIT with counter=20 -> next cycle state IDLE, pc=RESET_PC, retired=0, inst_valid=0; start then resumes from imem[0].
6. wait_time=0 with npc=0x13 -> treated as w=1; next state FETCH; pc=0x10; imem_addr=4.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    WAIT,
    HALT
  } fetch_state_t;

  localparam int unsigned WAIT_W = 5;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_wait_counter.sv
// Execute-stall countdown: loaded with w-1 on accept, done while the count is 1.
module fetch_wait_counter
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              tick,
  output logic              done
);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == WAIT_W'(1));

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, reads the 1-cycle BRAM and sequences
// replay, execute stall and halt from decode feedback.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       pc,
  output logic [31:0]       inst,
  output logic              inst_valid,
  input  logic [31:0]       npc,
  input  logic              hazard,
  input  logic              stop,
  input  logic [WAIT_W-1:0] wait_time,
  output logic              busy,
  output logic              halted,
  output logic [31:0]       retired
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  retired_q, retired_d;
  logic         replay_q, replay_d;

  logic              cnt_load;
  logic              cnt_tick;
  logic              cnt_done;
  logic [WAIT_W-1:0] w_eff;

  // A zero latency still needs one cycle, so it behaves exactly like w=1.
  assign w_eff = (wait_time == '0) ? WAIT_W'(1) : wait_time;

  fetch_wait_counter u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (w_eff - WAIT_W'(1)),
    .tick     (cnt_tick),
    .done     (cnt_done)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    replay_d  = replay_q;
    cnt_load  = 1'b0;
    cnt_tick  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        state_d = DECODE;
      end
      DECODE: begin
        // The replay flag limits hazard to one extra decode cycle per instruction.
        if (hazard && !replay_q) begin
          replay_d = 1'b1;
        end else if (stop) begin
          state_d = HALT;
        end else begin
          pc_d      = npc & ~32'h3;
          retired_d = retired_q + 32'd1;
          replay_d  = 1'b0;
          if (w_eff == WAIT_W'(1)) begin
            state_d = FETCH;
          end else begin
            state_d  = WAIT;
            cnt_load = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_tick = 1'b1;
        if (cnt_done) state_d = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      retired_q <= '0;
      replay_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      replay_q  <= replay_d;
    end
  end

  assign imem_addr  = pc_q[ADDR_W+1:2];
  assign pc         = pc_q;
  assign inst_valid = (state_q == DECODE);
  assign inst       = inst_valid ? imem_rdata : '0;
  assign busy       = (state_q == FETCH) || (state_q == DECODE) || (state_q == WAIT);
  assign halted     = (state_q == HALT);
  assign retired    = retired_q;

endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for the fetch stage with a behavioural 1-cycle BRAM.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] npc;
  logic        hazard;
  logic        stop;
  logic [4:0]  wait_time;
  logic        busy;
  logic        halted;
  logic [31:0] retired;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [31:0] imem [0:63];
  logic [31:0] saved_inst;

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= imem[imem_addr[5:0]];

  fetch #(.RESET_PC(32'h0000_0000), .ADDR_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .inst       (inst),
    .inst_valid (inst_valid),
    .npc        (npc),
    .hazard     (hazard),
    .stop       (stop),
    .wait_time  (wait_time),
    .busy       (busy),
    .halted     (halted),
    .retired    (retired)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'hA500_0000 + 32'(i);
    imem[0]    = 32'h0010_0093;
    imem_rdata = '0;
    rst = 1'b1; start = 1'b0; npc = '0; hazard = 1'b0; stop = 1'b0; wait_time = 5'd1;
    step(); step();

    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_retired", retired, 32'd0);

    // Test 1: first instruction
    rst = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_fetch_busy", {31'b0, busy}, 32'd1);
    chk("t1_fetch_valid", {31'b0, inst_valid}, 32'd0);
    chk("t1_fetch_addr", {16'b0, imem_addr}, 32'd0);
    npc = 32'h4; wait_time = 5'd1;
    step();
    chk("t1_dec_valid", {31'b0, inst_valid}, 32'd1);
    chk("t1_dec_pc", pc, 32'h0);
    chk("t1_dec_inst", inst, 32'h0010_0093);
    step();
    chk("t1_pc", pc, 32'h4);
    chk("t1_retired", retired, 32'd1);
    chk("t1_addr", {16'b0, imem_addr}, 32'd1);
    chk("t1_valid_low", {31'b0, inst_valid}, 32'd0);

    // Test 2: wait_time=5 gives 4 WAIT cycles
    step();
    chk("t2_dec_valid", {31'b0, inst_valid}, 32'd1);
    chk("t2_dec_inst", inst, 32'hA500_0001);
    npc = 32'h8; wait_time = 5'd5;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_wait_valid", {31'b0, inst_valid}, 32'd0);
      chk("t2_wait_busy", {31'b0, busy}, 32'd1);
      chk("t2_wait_inst", inst, 32'h0);
    end
    chk("t2_pc", pc, 32'h8);
    chk("t2_retired", retired, 32'd2);
    step();
    chk("t2_fetch_valid", {31'b0, inst_valid}, 32'd0);
    step();
    chk("t2_dec_again", {31'b0, inst_valid}, 32'd1);
    chk("t2_dec_inst2", inst, 32'hA500_0002);

    // Test 6: wait_time=0, misaligned npc
    npc = 32'h13; wait_time = 5'd0;
    step();
    chk("t6_valid", {31'b0, inst_valid}, 32'd0);
    chk("t6_pc", pc, 32'h10);
    chk("t6_addr", {16'b0, imem_addr}, 32'd4);
    chk("t6_retired", retired, 32'd3);
    step();
    chk("t6_dec", {31'b0, inst_valid}, 32'd1);
    npc = 32'h20; wait_time = 5'd1;
    step();
    chk("t3_pre_pc", pc, 32'h20);
    chk("t3_pre_ret", retired, 32'd4);

    // Test 3: hazard replay
    step();
    chk("t3_dec1_valid", {31'b0, inst_valid}, 32'd1);
    chk("t3_dec1_pc", pc, 32'h20);
    chk("t3_dec1_inst", inst, 32'hA500_0008);
    saved_inst = inst;
    hazard = 1'b1; npc = 32'h40;
    step();
    chk("t3_dec2_valid", {31'b0, inst_valid}, 32'd1);
    chk("t3_dec2_pc", pc, 32'h20);
    chk("t3_dec2_inst", inst, saved_inst);
    chk("t3_dec2_ret", retired, 32'd4);
    step();
    chk("t3_pc", pc, 32'h40);
    chk("t3_retired", retired, 32'd5);
    chk("t3_valid_low", {31'b0, inst_valid}, 32'd0);
    hazard = 1'b0;

    // Test 4: halt
    step();
    chk("t4_dec", {31'b0, inst_valid}, 32'd1);
    stop = 1'b1; npc = 32'h80;
    step();
    stop = 1'b0;
    chk("t4_halted", {31'b0, halted}, 32'd1);
    chk("t4_busy", {31'b0, busy}, 32'd0);
    chk("t4_valid", {31'b0, inst_valid}, 32'd0);
    chk("t4_pc", pc, 32'h40);
    chk("t4_retired", retired, 32'd5);
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("t4_still_halted", {31'b0, halted}, 32'd1);
    chk("t4_still_valid", {31'b0, inst_valid}, 32'd0);
    chk("t4_still_pc", pc, 32'h40);
    chk("t4_still_ret", retired, 32'd5);

    // Test 5: reset during WAIT with counter=20
    rst = 1'b1;
    step();
    rst = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t5_dec", {31'b0, inst_valid}, 32'd1);
    npc = 32'h4; wait_time = 5'd21;
    step();
    chk("t5_in_wait", {31'b0, busy}, 32'd1);
    chk("t5_wait_ret", retired, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_pc", pc, 32'h0);
    chk("t5_retired", retired, 32'd0);
    chk("t5_valid", {31'b0, inst_valid}, 32'd0);
    step();
    chk("t5_idle_stays", {31'b0, busy}, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_fetch_addr", {16'b0, imem_addr}, 32'd0);
    step();
    chk("t5_dec_inst", inst, 32'h0010_0093);
    chk("t5_dec_pc", pc, 32'h0);

    // wait_time=31: 30 WAIT cycles + 1 FETCH before the next DECODE
    npc = 32'h4; wait_time = 5'd31;
    for (int i = 0; i < 31; i++) begin
      step();
      chk("w31_valid_low", {31'b0, inst_valid}, 32'd0);
    end
    step();
    chk("w31_dec", {31'b0, inst_valid}, 32'd1);
    chk("w31_pc", pc, 32'h4);
    chk("w31_ret", retired, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
